ahb_lite_mem_slave: RTL and testbench

AHB-Lite subordinate that terminates AHB-Lite transfers and converts them into a simple request/acknowledge memory interface with variable latency. It sits behind the AHB-Lite decoder/mux and fronts SRAMs, register files or peripheral cores. It inserts wait states until the backend acknowledges. It returns the two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_lite_pkg.sv | 48 ++++
 rtl/ahb_lite_be_gen.sv | 40 ++++
 rtl/ahb_lite_mem_slave.sv | 121 ++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types: transfer/size/burst/prot/resp encodings and the
// memory-slave FSM state.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        AHB_TRANS_IDLE   = 2'b00,
        AHB_TRANS_BUSY   = 2'b01,
        AHB_TRANS_NONSEQ = 2'b10,
        AHB_TRANS_SEQ    = 2'b11
    } ahb_trans_t;

    typedef enum logic [2:0] {
        AHB_SIZE_BYTE  = 3'd0,
        AHB_SIZE_HALF  = 3'd1,
        AHB_SIZE_WORD  = 3'd2,
        AHB_SIZE_DWORD = 3'd3,
        AHB_SIZE_4W    = 3'd4,
        AHB_SIZE_8W    = 3'd5,
        AHB_SIZE_16W   = 3'd6,
        AHB_SIZE_32W   = 3'd7
    } ahb_size_t;

    typedef enum logic [2:0] {
        AHB_BURST_SINGLE = 3'd0,
        AHB_BURST_INCR   = 3'd1,
        AHB_BURST_WRAP4  = 3'd2,
        AHB_BURST_INCR4  = 3'd3,
        AHB_BURST_WRAP8  = 3'd4,
        AHB_BURST_INCR8  = 3'd5,
        AHB_BURST_WRAP16 = 3'd6,
        AHB_BURST_INCR16 = 3'd7
    } ahb_burst_t;

    typedef logic [3:0] ahb_prot_t;

    typedef enum logic {
        AHB_RESP_OKAY  = 1'b0,
        AHB_RESP_ERROR = 1'b1
    } ahb_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_slave_state_t;

endpackage

// File: rtl/ahb_lite_be_gen.sv
// Combinational decode of transfer size/address into an aligned address,
// byte-lane enables and a legality flag (size fits the bus, address aligned).
module ahb_lite_be_gen
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  ahb_size_t               size,
    output logic [ADDR_WIDTH-1:0]   addr_aligned,
    output logic [DATA_WIDTH/8-1:0] be,
    output logic                    legal
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);

    logic                  size_ok;
    logic [2:0]            eff_size;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] eff_mask;
    logic [LB-1:0]         lane;

    always_comb begin
        size_ok      = (int'(size) <= LB);
        // Oversize transfers are clamped so the decode stays in range even
        // when the caller discards the legality flag.
        eff_size     = size_ok ? 3'(size) : 3'(LB);
        size_mask    = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        eff_mask     = (ADDR_WIDTH'(1) << eff_size) - ADDR_WIDTH'(1);
        legal        = size_ok && ((addr & size_mask) == '0);
        addr_aligned = addr & ~eff_mask;
        lane         = addr_aligned[LB-1:0];
        be           = '0;
        for (int i = 0; i < LANES; i++) begin
            be[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << eff_size));
        end
    end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite subordinate bridging to a req/ack memory port with wait states.
// Define AHB_LITE_MEM_SLAVE_ERR_EN to enable the legality check and ERROR response.
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    hsel_i,
    input  logic [ADDR_WIDTH-1:0]   haddr_i,
    input  ahb_trans_t              htrans_i,
    input  ahb_size_t               hsize_i,
    input  ahb_burst_t              hburst_i,
    input  logic [3:0]              hprot_i,
    input  logic                    hwrite_i,
    input  logic                    hready_i,
    input  logic [DATA_WIDTH-1:0]   hwdata_i,
    output logic                    hreadyout_o,
    output logic                    hresp_o,
    output logic [DATA_WIDTH-1:0]   hrdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int LANES = DATA_WIDTH / 8;

    ahb_slave_state_t      state_q, state_d;
    logic                  accept, can_acc, legal, chk_legal;
    logic [ADDR_WIDTH-1:0] addr_al, addr_q;
    logic [LANES-1:0]      be_nxt, be_q;
    logic                  we_q;

    // Burst type and protection carry no meaning for a flat memory.
    logic unused_in;
    assign unused_in = ^{hburst_i, hprot_i};

    assign accept = hsel_i & hready_i &
                    ((htrans_i == AHB_TRANS_NONSEQ) || (htrans_i == AHB_TRANS_SEQ));

    ahb_lite_be_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_be_gen (
        .addr         (haddr_i),
        .size         (hsize_i),
        .addr_aligned (addr_al),
        .be           (be_nxt),
        .legal        (chk_legal)
    );

`ifdef AHB_LITE_MEM_SLAVE_ERR_EN
    assign legal = chk_legal;
`else
    logic unused_legal;
    assign unused_legal = chk_legal;
    assign legal        = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        can_acc     = 1'b0;
        hreadyout_o = 1'b1;
        hresp_o     = AHB_RESP_OKAY;
        mem_req_o   = 1'b0;
        hrdata_o    = '0;
        unique case (state_q)
            ST_IDLE: can_acc = 1'b1;
            ST_DATA: begin
                mem_req_o   = 1'b1;
                hreadyout_o = mem_ack_i;
                hrdata_o    = mem_rdata_i;
                can_acc     = mem_ack_i;
                if (mem_ack_i) state_d = ST_IDLE;
            end
`ifdef AHB_LITE_MEM_SLAVE_ERR_EN
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = AHB_RESP_ERROR;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o = AHB_RESP_ERROR;
                can_acc = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (can_acc && accept) state_d = legal ? ST_DATA : ST_ERR1;
    end

    // Backend fields are only refreshed by a legal accept, so they stay
    // frozen for the whole data phase.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (can_acc && accept && legal) begin
                addr_q <= addr_al;
                be_q   <= be_nxt;
                we_q   <= hwrite_i;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = hwdata_i;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench for ahb_lite_mem_slave: directed scenarios plus random
// transfers checked cycle by cycle against a transaction-level model.
module tb_ahb_lite_mem_slave;
    import ahb_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i   = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          hsel_i  = 1'b0;
    logic [AW-1:0] haddr_i = '0;
    ahb_trans_t    htrans_i = AHB_TRANS_IDLE;
    ahb_size_t     hsize_i  = AHB_SIZE_BYTE;
    ahb_burst_t    hburst_i = AHB_BURST_SINGLE;
    logic [3:0]    hprot_i  = 4'h0;
    logic          hwrite_i = 1'b0;
    logic          hready_i;
    logic [DW-1:0] hwdata_i = '0;
    logic          hreadyout_o;
    logic          hresp_o;
    logic [DW-1:0] hrdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i   = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Single slave on the bus: the bus HREADY is this slave's HREADYOUT.
    assign hready_i = hreadyout_o;

    always #5 clk_i = ~clk_i;

    ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .hsel_i(hsel_i), .haddr_i(haddr_i),
        .htrans_i(htrans_i), .hsize_i(hsize_i), .hburst_i(hburst_i),
        .hprot_i(hprot_i), .hwrite_i(hwrite_i), .hready_i(hready_i),
        .hwdata_i(hwdata_i), .hreadyout_o(hreadyout_o), .hresp_o(hresp_o),
        .hrdata_o(hrdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          size;
        bit          write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        bit          seq;
        int          gap;
    } xfer_t;

    xfer_t xq[$];

    // Reference: sizes beyond the 4-byte bus clamp to a word, address aligns down.
    function automatic logic [31:0] m_addr(logic [31:0] a, int s);
        int es = (s > 2) ? 2 : s;
        return a & ~((32'd1 << es) - 32'd1);
    endfunction

    function automatic logic [3:0] m_be(logic [31:0] a, int s);
        int es  = (s > 2) ? 2 : s;
        int n   = 1 << es;
        int off = int'(m_addr(a, s) % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    // Acts as AHB manager and backend for the queued transfers, checking every cycle.
    task automatic run_queue(input string name, output int cycles);
        xfer_t       cur, t;
        bit          cur_v, drive_a, ack_now, rdy_exp;
        int          wcnt;
        logic [31:0] ea;
        logic [3:0]  eb;
        cur_v  = 0;
        wcnt   = 0;
        cycles = 0;
        @(posedge clk_i); #1;
        while ((xq.size() > 0 || cur_v) && cycles < 400) begin
            drive_a = 0;
            if (xq.size() > 0) begin
                if (xq[0].gap > 0) begin
                    t = xq[0]; t.gap--; xq[0] = t;
                end else drive_a = 1;
            end
            hsel_i = 1'b1;
            if (drive_a) begin
                htrans_i = xq[0].seq ? AHB_TRANS_SEQ : AHB_TRANS_NONSEQ;
                haddr_i  = xq[0].addr;
                hsize_i  = ahb_size_t'(xq[0].size);
                hwrite_i = xq[0].write;
                hburst_i = xq[0].seq ? AHB_BURST_INCR4 : AHB_BURST_SINGLE;
                hprot_i  = 4'($urandom);
            end else begin
                htrans_i = ($urandom_range(0, 1) != 0) ? AHB_TRANS_IDLE : AHB_TRANS_BUSY;
                haddr_i  = $urandom;
            end
            ack_now     = cur_v && (wcnt == cur.lat);
            rdy_exp     = !cur_v || ack_now;
            mem_ack_i   = ack_now;
            mem_rdata_i = cur_v ? cur.rdata : $urandom;
            hwdata_i    = cur_v ? cur.wdata : '0;
            #4;
            if (cur_v) begin
                ea = m_addr(cur.addr, cur.size);
                eb = m_be(cur.addr, cur.size);
                n_cmp++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== ea || mem_be_o !== eb || mem_we_o !== cur.write) begin
                    n_bad++;
                    $display("FAIL %s mem_ctrl: got req=%b addr=%h be=%b we=%b, expected req=1 addr=%h be=%b we=%b",
                             name, mem_req_o, mem_addr_o, mem_be_o, mem_we_o, ea, eb, cur.write);
                end
                n_cmp++;
                if (hreadyout_o !== ack_now || hresp_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s data_ready: got hreadyout=%b hresp=%b, expected hreadyout=%b hresp=0",
                             name, hreadyout_o, hresp_o, ack_now);
                end
                n_cmp++;
                if (hrdata_o !== cur.rdata || mem_wdata_o !== cur.wdata) begin
                    n_bad++;
                    $display("FAIL %s data: got hrdata=%h mem_wdata=%h, expected hrdata=%h mem_wdata=%h",
                             name, hrdata_o, mem_wdata_o, cur.rdata, cur.wdata);
                end
            end else begin
                n_cmp++;
                if (mem_req_o !== 1'b0 || hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== '0) begin
                    n_bad++;
                    $display("FAIL %s idle: got req=%b hreadyout=%b hresp=%b hrdata=%h, expected 0/1/0/0",
                             name, mem_req_o, hreadyout_o, hresp_o, hrdata_o);
                end
            end
            @(posedge clk_i); #1;
            if (cur_v) begin
                if (ack_now) cur_v = 0;
                else wcnt++;
            end
            if (drive_a && rdy_exp) begin
                cur   = xq.pop_front();
                cur_v = 1;
                wcnt  = 0;
            end
            cycles++;
        end
        if (cycles >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: got %0d cycles, expected completion", name, cycles);
            xq.delete();
        end
        htrans_i  = AHB_TRANS_IDLE;
        hsel_i    = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== '0 || mem_req_o !== 1'b0 ||
            mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_be_o !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b resp=%b rdata=%h req=%b we=%b addr=%h be=%b, expected 1/0/0/0/0/0/0",
                     hreadyout_o, hresp_o, hrdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #4;
            n_cmp++;
            if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || mem_req_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release: got rdy=%b resp=%b req=%b, expected 1/0/0", hreadyout_o, hresp_o, mem_req_o);
            end
        end
    endtask

    task automatic test_write_wait();
        int cyc;
        xq.push_back('{addr: 32'h104, size: 2, write: 1, wdata: 32'hDEADBEEF, rdata: 32'h0, lat: 2, seq: 0, gap: 0});
        run_queue("write_wait", cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_bad++;
            $display("FAIL write_wait_len: got %0d cycles, expected 4", cyc);
        end
    endtask

    task automatic test_byte_read();
        int cyc;
        xq.push_back('{addr: 32'h203, size: 0, write: 0, wdata: 32'h0, rdata: 32'hAA000000, lat: 0, seq: 0, gap: 0});
        run_queue("byte_read", cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL byte_read_len: got %0d cycles, expected 2", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int i = 0; i < 4; i++)
            xq.push_back('{addr: 32'(i * 4), size: 2, write: 0, wdata: 32'h0, rdata: $urandom,
                           lat: 0, seq: (i != 0), gap: 0});
        run_queue("incr4", cyc);
        n_cmp++;
        if (cyc !== 5) begin
            n_bad++;
            $display("FAIL incr4_len: got %0d cycles, expected 5", cyc);
        end
    endtask

    task automatic test_idle_busy();
        @(posedge clk_i); #1;
        hsel_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            htrans_i    = (i % 2 == 0) ? AHB_TRANS_IDLE : AHB_TRANS_BUSY;
            haddr_i     = $urandom;
            mem_ack_i   = (i >= 2);
            mem_rdata_i = 32'hFFFF_FFFF;
            #4;
            n_cmp++;
            if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || mem_req_o !== 1'b0 || hrdata_o !== '0) begin
                n_bad++;
                $display("FAIL idle_busy: got rdy=%b resp=%b req=%b rdata=%h, expected 1/0/0/0",
                         hreadyout_o, hresp_o, mem_req_o, hrdata_o);
            end
            @(posedge clk_i); #1;
        end
        hsel_i    = 1'b0;
        htrans_i  = AHB_TRANS_IDLE;
        mem_ack_i = 1'b0;
    endtask

`ifdef AHB_LITE_MEM_SLAVE_ERR_EN
    task automatic test_error();
        @(posedge clk_i); #1;
        hsel_i = 1'b1; htrans_i = AHB_TRANS_NONSEQ; haddr_i = 32'h102;
        hsize_i = AHB_SIZE_WORD; hwrite_i = 1'b1;
        @(posedge clk_i); #1;
        htrans_i = AHB_TRANS_NONSEQ; haddr_i = 32'h100; hsize_i = AHB_SIZE_WORD; hwrite_i = 1'b0;
        mem_ack_i = 1'b1;
        #4;
        n_cmp++;
        if (hreadyout_o !== 1'b0 || hresp_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err1: got rdy=%b resp=%b req=%b, expected 0/1/0", hreadyout_o, hresp_o, mem_req_o);
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        #4;
        n_cmp++;
        if (hreadyout_o !== 1'b1 || hresp_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err2: got rdy=%b resp=%b req=%b, expected 1/1/0", hreadyout_o, hresp_o, mem_req_o);
        end
        @(posedge clk_i); #1;
        htrans_i = AHB_TRANS_IDLE; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #4;
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b0 ||
            hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL err_next: got req=%b addr=%h be=%b we=%b rdy=%b resp=%b rdata=%h, expected 1/100/1111/0/1/0/12345678",
                     mem_req_o, mem_addr_o, mem_be_o, mem_we_o, hreadyout_o, hresp_o, hrdata_o);
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0; hsel_i = 1'b0;
    endtask
`else
    task automatic test_clamp();
        int cyc;
        xq.push_back('{addr: 32'h106, size: 3, write: 1, wdata: 32'hCAFE0001, rdata: 32'h0, lat: 1, seq: 0, gap: 0});
        xq.push_back('{addr: 32'h103, size: 1, write: 0, wdata: 32'h0, rdata: 32'h5A5A0000, lat: 0, seq: 0, gap: 0});
        run_queue("clamp_align", cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_bad++;
            $display("FAIL clamp_len: got %0d cycles, expected 4", cyc);
        end
    endtask
`endif

    task automatic test_random();
        int          cyc, s;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
`ifdef AHB_LITE_MEM_SLAVE_ERR_EN
            s = $urandom_range(0, 2);
            a = $urandom & ~((32'd1 << s) - 32'd1);
`else
            s = $urandom_range(0, 7);
            a = $urandom;
`endif
            xq.push_back('{addr: a, size: s, write: bit'($urandom_range(0, 1)), wdata: $urandom,
                           rdata: $urandom, lat: $urandom_range(0, 3), seq: bit'($urandom_range(0, 1)),
                           gap: ($urandom_range(0, 3) == 0) ? 1 : 0});
        end
        run_queue("random", cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(posedge clk_i); #1;
        hsel_i = 1'b1; htrans_i = AHB_TRANS_NONSEQ; haddr_i = 32'h40;
        hsize_i = AHB_SIZE_WORD; hwrite_i = 1'b1;
        @(posedge clk_i); #1;
        htrans_i = AHB_TRANS_IDLE; mem_ack_i = 1'b0; hwdata_i = 32'h1111_2222;
        #2;
        n_cmp++;
        if (mem_req_o !== 1'b1 || hreadyout_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got req=%b rdy=%b, expected 1/0", mem_req_o, hreadyout_o);
        end
        rst_n_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b0 || hreadyout_o !== 1'b1 || mem_addr_o !== '0 || mem_we_o !== 1'b0 || mem_be_o !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got req=%b rdy=%b addr=%h we=%b be=%b, expected 0/1/0/0/0",
                     mem_req_o, hreadyout_o, mem_addr_o, mem_we_o, mem_be_o);
        end
        hsel_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        xq.push_back('{addr: 32'h80, size: 2, write: 1, wdata: 32'h0BAD_F00D, rdata: 32'h0, lat: 1, seq: 0, gap: 0});
        run_queue("after_reset", cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++;
            $display("FAIL after_reset_len: got %0d cycles, expected 3", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_write_wait();
        test_byte_read();
        test_back_to_back();
        test_idle_busy();
`ifdef AHB_LITE_MEM_SLAVE_ERR_EN
        test_error();
`else
        test_clamp();
`endif
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
